// File: rtl/his_peak_builder.sv
// rtl/his_peak_builder.sv - multi-pixel TDC histogram builder with per-pixel peak search
// Define HIS_PEAK3_EN to rank bins by the 3-bin window sum instead of the single-bin count.
module his_peak_builder #(
    parameter int TDC_W  = 10,
    parameter int BIN_W  = 6,
    parameter int PIXELS = 3,
    parameter int CNT_W  = 8,
    localparam int PIX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             wrEn,
    input  logic [TDC_W-1:0] data,
    input  logic [PIX_W-1:0] pixel,
    input  logic             frameEnd,
    output logic             busy,
    output logic             peakValid,
    input  logic             peakReady,
    output logic [PIX_W-1:0] peakPixel,
    output logic [BIN_W-1:0] peakBin,
    output logic [CNT_W+1:0] peakCount,
    output logic [15:0]      dropCount
);
    localparam int BINS  = 2**BIN_W;
    localparam int DEPTH = PIXELS * BINS;
    localparam int AW    = PIX_W + BIN_W;
    localparam int SW    = BIN_W + 2;
`ifdef HIS_PEAK3_EN
    localparam int NRD = BINS + 1;
`else
    localparam int NRD = BINS;
`endif
    localparam logic [PIX_W:0] PIX_LIM = (PIX_W+1)'(PIXELS);

    typedef enum logic [2:0] {CLEAR, ACCUM, DRAIN, SCAN, OUT} state_t;

    state_t           state_q;
    logic [AW-1:0]    clr_q;
    logic             drain_q;
    logic             s1_valid_q, wb_valid_q;
    logic [AW-1:0]    s1_addr_q, wb_addr_q;
    logic [CNT_W-1:0] wb_data_q;
    logic [15:0]      drop_q;
    logic [PIX_W-1:0] scan_pix_q;
    logic [SW-1:0]    scan_cnt_q;
    logic             cmp_valid_q, cmp_zero_q;
    logic [BIN_W-1:0] cmp_bin_q, best_bin_q;
    logic [CNT_W+1:0] best_cnt_q;
    logic             peak_valid_q;
    logic [PIX_W-1:0] peak_pix_q;
    logic [BIN_W-1:0] peak_bin_q;
    logic [CNT_W+1:0] peak_cnt_q;
`ifdef HIS_PEAK3_EN
    logic             cmp_first_q;
    logic [CNT_W+1:0] w1_q, w2_q;
`endif

    logic [CNT_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0] rd_q;

    logic             pixel_ok, accept, drop, fe_accept, scan_rd, metric_ok;
    logic             mem_we, mem_re;
    logic [AW-1:0]    in_addr, scan_addr, mem_waddr, mem_raddr;
    logic [CNT_W-1:0] mem_wdata, base_d, inc_d;
    logic [BIN_W-1:0] scan_bin_d;
    logic [CNT_W+1:0] cmp_val_d, metric_d;
    logic             unused_data;

    assign unused_data = ^{1'b0, data};
    assign busy        = (state_q != ACCUM);
    assign pixel_ok    = ({1'b0, pixel} < PIX_LIM);
    assign accept      = (state_q == ACCUM) && wrEn && pixel_ok;
    assign drop        = wrEn && (!pixel_ok || busy);
    assign fe_accept   = (state_q == ACCUM) && frameEnd;
    assign in_addr     = {pixel, data[TDC_W-1 -: BIN_W]};
    assign scan_rd     = (state_q == SCAN) && (scan_cnt_q < SW'(BINS));
    assign scan_addr   = {scan_pix_q, scan_cnt_q[BIN_W-1:0]};

    always_comb begin
        // The write landing this edge is not yet visible to the read issued alongside it.
        base_d    = (wb_valid_q && (wb_addr_q == s1_addr_q)) ? wb_data_q : rd_q;
        inc_d     = (base_d == {CNT_W{1'b1}}) ? base_d : base_d + CNT_W'(1);
        mem_re    = accept || scan_rd;
        mem_raddr = scan_rd ? scan_addr : in_addr;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_q;
        end else if (s1_valid_q) begin
            mem_we    = 1'b1;
            mem_waddr = s1_addr_q;
            mem_wdata = inc_d;
        end else if (scan_rd) begin
            mem_we    = 1'b1;
            mem_waddr = scan_addr;
        end
        cmp_val_d = cmp_zero_q ? '0 : {2'b00, rd_q};
`ifdef HIS_PEAK3_EN
        scan_bin_d = BIN_W'(scan_cnt_q - SW'(1));
        metric_d   = w2_q + w1_q + cmp_val_d;
        metric_ok  = !cmp_first_q;
`else
        scan_bin_d = scan_cnt_q[BIN_W-1:0];
        metric_d   = cmp_val_d;
        metric_ok  = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (mem_re) rd_q <= mem[mem_raddr];
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q      <= CLEAR;
            clr_q        <= '0;
            drain_q      <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_addr_q    <= '0;
            wb_valid_q   <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            drop_q       <= '0;
            scan_pix_q   <= '0;
            scan_cnt_q   <= '0;
            cmp_valid_q  <= 1'b0;
            cmp_zero_q   <= 1'b0;
            cmp_bin_q    <= '0;
            best_bin_q   <= '0;
            best_cnt_q   <= '0;
            peak_valid_q <= 1'b0;
            peak_pix_q   <= '0;
            peak_bin_q   <= '0;
            peak_cnt_q   <= '0;
`ifdef HIS_PEAK3_EN
            cmp_first_q  <= 1'b0;
            w1_q         <= '0;
            w2_q         <= '0;
`endif
        end else begin
            s1_valid_q <= accept;
            s1_addr_q  <= in_addr;
            wb_valid_q <= s1_valid_q;
            wb_addr_q  <= s1_addr_q;
            wb_data_q  <= inc_d;
            if (fe_accept)
                drop_q <= '0;
            else if (drop && (drop_q != 16'hFFFF))
                drop_q <= drop_q + 16'd1;

            cmp_valid_q <= (state_q == SCAN) && (scan_cnt_q < SW'(NRD));
            cmp_zero_q  <= (scan_cnt_q >= SW'(BINS));
            cmp_bin_q   <= scan_bin_d;
`ifdef HIS_PEAK3_EN
            cmp_first_q <= (scan_cnt_q == '0);
            if (cmp_valid_q) begin
                w2_q <= w1_q;
                w1_q <= cmp_val_d;
            end
`endif
            // Strictly greater keeps the lowest bin on ties.
            if (cmp_valid_q && metric_ok && (metric_d > best_cnt_q)) begin
                best_cnt_q <= metric_d;
                best_bin_q <= cmp_bin_q;
            end

            case (state_q)
                CLEAR: begin
                    clr_q <= clr_q + AW'(1);
                    if (clr_q == AW'(DEPTH-1)) begin
                        clr_q   <= '0;
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (frameEnd) begin
                        drain_q <= 1'b0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    drain_q    <= 1'b1;
                    scan_pix_q <= '0;
                    scan_cnt_q <= '0;
                    best_cnt_q <= '0;
                    best_bin_q <= '0;
`ifdef HIS_PEAK3_EN
                    w1_q <= '0;
                    w2_q <= '0;
`endif
                    if (drain_q) state_q <= SCAN;
                end
                SCAN: begin
                    scan_cnt_q <= scan_cnt_q + SW'(1);
                    if (scan_cnt_q == SW'(NRD+1)) begin
                        state_q      <= OUT;
                        peak_valid_q <= 1'b1;
                        peak_pix_q   <= scan_pix_q;
                        peak_bin_q   <= best_bin_q;
                        peak_cnt_q   <= best_cnt_q;
                    end
                end
                OUT: begin
                    scan_cnt_q <= '0;
                    best_cnt_q <= '0;
                    best_bin_q <= '0;
`ifdef HIS_PEAK3_EN
                    w1_q <= '0;
                    w2_q <= '0;
`endif
                    if (peakReady) begin
                        peak_valid_q <= 1'b0;
                        if (scan_pix_q == PIX_W'(PIXELS-1)) begin
                            state_q <= ACCUM;
                        end else begin
                            scan_pix_q <= scan_pix_q + PIX_W'(1);
                            state_q    <= SCAN;
                        end
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign peakValid = peak_valid_q;
    assign peakPixel = peak_pix_q;
    assign peakBin   = peak_bin_q;
    assign peakCount = peak_cnt_q;
    assign dropCount = drop_q;
endmodule

// File: tb/tb_his_peak_builder.sv
// tb/tb_his_peak_builder.sv - directed self-checking bench for his_peak_builder
// Expected values follow HIS_PEAK3_EN when the bench is built with it defined.
module tb_his_peak_builder;
`ifdef HIS_PEAK3_EN
    localparam int FV = 69, TURN = 206, SP_BIN = 5, SAT_BIN = 62, TIE_BIN = 9;
    localparam int DROP_BIN = 4, W_BIN = 5, W_CNT = 6;
`else
    localparam int FV = 68, TURN = 203, SP_BIN = 6, SAT_BIN = 63, TIE_BIN = 10;
    localparam int DROP_BIN = 5, W_BIN = 20, W_CNT = 5;
`endif

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       wrEn = 1'b0;
    logic [9:0] data = '0;
    logic [1:0] pixel = '0;
    logic       frameEnd = 1'b0;
    logic       busy, peakValid;
    logic       peakReady = 1'b0;
    logic [1:0] peakPixel;
    logic [5:0] peakBin;
    logic [9:0] peakCount;
    logic [15:0] dropCount;

    int checks = 0;
    int failures = 0;

    his_peak_builder dut (
        .clk(clk), .res(res), .wrEn(wrEn), .data(data), .pixel(pixel),
        .frameEnd(frameEnd), .busy(busy), .peakValid(peakValid),
        .peakReady(peakReady), .peakPixel(peakPixel), .peakBin(peakBin),
        .peakCount(peakCount), .dropCount(dropCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] p, input logic [9:0] d);
        wrEn = 1'b1; pixel = p; data = d;
        tick();
        wrEn = 1'b0;
    endtask

    task automatic frame_end();
        frameEnd = 1'b1;
        tick();
        frameEnd = 1'b0;
    endtask

    task automatic get_result(output bit ok, output logic [1:0] p, output logic [5:0] b,
                              output logic [9:0] c);
        int n = 0;
        while (peakValid !== 1'b1 && n < 500) begin tick(); n++; end
        ok = (peakValid === 1'b1);
        p = peakPixel; b = peakBin; c = peakCount;
        if (ok) begin
            peakReady = 1'b1;
            tick();
            peakReady = 1'b0;
        end
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy !== 1'b0 && n < 2000) begin tick(); n++; end
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset();
        int n = 0;
        res = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b1 || peakValid !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl: busy=%0b peakValid=%0b, required 1/0", busy, peakValid);
        end
        checks++;
        if (peakPixel !== 2'd0 || peakBin !== 6'd0 || peakCount !== 10'd0) begin
            failures++; $display("FAIL reset_payload: pix=%0d bin=%0d cnt=%0d, required 0", peakPixel, peakBin, peakCount);
        end
        checks++;
        if (dropCount !== 16'd0) begin
            failures++; $display("FAIL reset_drop: dropCount=%0d, required 0", dropCount);
        end
        res = 1'b1;
        while (busy === 1'b1 && n < 1000) begin tick(); n++; end
        checks++;
        if (n != 192 || busy !== 1'b0) begin
            failures++; $display("FAIL clear_len: busy cycles=%0d busy=%0b, required 192 then 0", n, busy);
        end
    endtask

    task automatic test_turnaround();
        int n = 0, first = -1, hs = 0;
        bit bad = 0;
        peakReady = 1'b1;
        frame_end();
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL busy_rise: busy=%0b, required 1", busy);
        end
        while (n < 1000) begin
            tick(); n++;
            if (peakValid === 1'b1) begin
                if (first < 0) first = n;
                if (peakPixel !== 2'(hs) || peakBin !== 6'd0 || peakCount !== 10'd0) bad = 1;
                hs++;
            end
            if (busy === 1'b0) break;
        end
        peakReady = 1'b0;
        checks++;
        if (first != FV) begin
            failures++; $display("FAIL first_valid: cycle=%0d, required %0d", first, FV);
        end
        checks++;
        if (n != TURN || busy !== 1'b0) begin
            failures++; $display("FAIL turnaround: cycles=%0d busy=%0b, required %0d then 0", n, busy, TURN);
        end
        checks++;
        if (hs != 3 || bad) begin
            failures++; $display("FAIL empty_results: handshakes=%0d payload_bad=%0b, required 3/0", hs, bad);
        end
    endtask

    task automatic test_single_peak();
        int eb[3] = '{SP_BIN, 0, 0};
        int ec[3] = '{3, 0, 0};
        bit ok; logic [1:0] p; logic [5:0] b; logic [9:0] c;
        send(0, 108); send(0, 108); send(0, 108); send(0, 511); send(0, 1022);
        wrEn = 1'b1; pixel = 0; data = 10'd1022; frameEnd = 1'b1;
        tick();
        wrEn = 1'b0; frameEnd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            get_result(ok, p, b, c);
            checks++;
            if (!ok || p !== 2'(i) || b !== 6'(eb[i]) || c !== 10'(ec[i])) begin
                failures++;
                $display("FAIL single_peak px%0d: ok=%0b pix=%0d bin=%0d cnt=%0d, required pix=%0d bin=%0d cnt=%0d",
                         i, ok, p, b, c, i, eb[i], ec[i]);
            end
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_idle: busy=%0b, required 0", busy); end
    endtask

    task automatic test_saturation();
        int eb[3] = '{0, 0, SAT_BIN};
        int ec[3] = '{0, 0, 255};
        bit ok; logic [1:0] p; logic [5:0] b; logic [9:0] c;
        wrEn = 1'b1; pixel = 2; data = 10'd1023;
        repeat (300) tick();
        wrEn = 1'b0;
        frame_end();
        for (int i = 0; i < 3; i++) begin
            get_result(ok, p, b, c);
            checks++;
            if (!ok || p !== 2'(i) || b !== 6'(eb[i]) || c !== 10'(ec[i])) begin
                failures++;
                $display("FAIL saturation px%0d: ok=%0b pix=%0d bin=%0d cnt=%0d, required pix=%0d bin=%0d cnt=%0d",
                         i, ok, p, b, c, i, eb[i], ec[i]);
            end
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL sat_idle: busy=%0b, required 0", busy); end
    endtask

    task automatic test_tie_backpressure();
        bit ok, moved = 0; int n = 0;
        logic [1:0] p; logic [5:0] b; logic [9:0] c;
        send(1, 160); send(1, 640); send(1, 160); send(1, 640);
        frame_end();
        get_result(ok, p, b, c);
        checks++;
        if (!ok || p !== 2'd0 || b !== 6'd0 || c !== 10'd0) begin
            failures++; $display("FAIL tie_px0: ok=%0b pix=%0d bin=%0d cnt=%0d, required 0/0/0", ok, p, b, c);
        end
        while (peakValid !== 1'b1 && n < 500) begin tick(); n++; end
        p = peakPixel; b = peakBin; c = peakCount;
        repeat (20) begin
            tick();
            if (peakValid !== 1'b1 || peakPixel !== p || peakBin !== b || peakCount !== c) moved = 1;
        end
        checks++;
        if (moved || p !== 2'd1 || b !== 6'(TIE_BIN) || c !== 10'd2) begin
            failures++;
            $display("FAIL tie_stall: unstable=%0b pix=%0d bin=%0d cnt=%0d, required stable pix=1 bin=%0d cnt=2",
                     moved, p, b, c, TIE_BIN);
        end
        peakReady = 1'b1; tick(); peakReady = 1'b0;
        get_result(ok, p, b, c);
        checks++;
        if (!ok || p !== 2'd2 || b !== 6'd0 || c !== 10'd0) begin
            failures++; $display("FAIL tie_px2: ok=%0b pix=%0d bin=%0d cnt=%0d, required 2/0/0", ok, p, b, c);
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL tie_idle: busy=%0b, required 0", busy); end
    endtask

    task automatic test_drops();
        int eb[3] = '{DROP_BIN, 0, 0};
        int ec[3] = '{1, 0, 0};
        bit ok; logic [1:0] p; logic [5:0] b; logic [9:0] c;
        frame_end();
        repeat (5) send(0, 800);
        checks++;
        if (dropCount !== 16'd5) begin
            failures++; $display("FAIL drop_busy: dropCount=%0d, required 5", dropCount);
        end
        for (int i = 0; i < 3; i++) begin
            get_result(ok, p, b, c);
            checks++;
            if (!ok || p !== 2'(i) || b !== 6'd0 || c !== 10'd0) begin
                failures++; $display("FAIL drop_empty px%0d: ok=%0b bin=%0d cnt=%0d, required 0/0", i, ok, b, c);
            end
        end
        wait_idle(ok);
        send(3, 800);
        send(0, 80);
        checks++;
        if (dropCount !== 16'd6) begin
            failures++; $display("FAIL drop_total: dropCount=%0d, required 6", dropCount);
        end
        frame_end();
        checks++;
        if (dropCount !== 16'd0) begin
            failures++; $display("FAIL drop_clear: dropCount=%0d, required 0", dropCount);
        end
        for (int i = 0; i < 3; i++) begin
            get_result(ok, p, b, c);
            checks++;
            if (!ok || p !== 2'(i) || b !== 6'(eb[i]) || c !== 10'(ec[i])) begin
                failures++;
                $display("FAIL drop_hist px%0d: ok=%0b pix=%0d bin=%0d cnt=%0d, required bin=%0d cnt=%0d",
                         i, ok, p, b, c, eb[i], ec[i]);
            end
        end
        wait_idle(ok);
    endtask

    task automatic test_window();
        int eb[3] = '{W_BIN, 0, 0};
        int ec[3] = '{W_CNT, 0, 0};
        bit ok; logic [1:0] p; logic [5:0] b; logic [9:0] c;
        repeat (3) send(0, 64);
        repeat (3) send(0, 96);
        repeat (5) send(0, 320);
        frame_end();
        for (int i = 0; i < 3; i++) begin
            get_result(ok, p, b, c);
            checks++;
            if (!ok || p !== 2'(i) || b !== 6'(eb[i]) || c !== 10'(ec[i])) begin
                failures++;
                $display("FAIL window px%0d: ok=%0b pix=%0d bin=%0d cnt=%0d, required bin=%0d cnt=%0d",
                         i, ok, p, b, c, eb[i], ec[i]);
            end
        end
        wait_idle(ok);
    endtask

    task automatic test_reset_mid();
        bit ok; logic [1:0] p; logic [5:0] b; logic [9:0] c;
        repeat (3) send(1, 200);
        send(3, 0);
        frame_end();
        repeat (10) tick();
        res = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b1 || peakValid !== 1'b0 || dropCount !== 16'd0) begin
            failures++;
            $display("FAIL mid_reset: busy=%0b peakValid=%0b drop=%0d, required 1/0/0", busy, peakValid, dropCount);
        end
        res = 1'b1;
        wait_idle(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL mid_clear: busy=%0b, required 0", busy); end
        frame_end();
        for (int i = 0; i < 3; i++) begin
            get_result(ok, p, b, c);
            checks++;
            if (!ok || p !== 2'(i) || b !== 6'd0 || c !== 10'd0) begin
                failures++; $display("FAIL mid_empty px%0d: ok=%0b bin=%0d cnt=%0d, required 0/0", i, ok, b, c);
            end
        end
        wait_idle(ok);
    endtask

    initial begin
        test_reset();
        test_turnaround();
        test_single_peak();
        test_saturation();
        test_tie_backpressure();
        test_drops();
        test_window();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/his_peak_builder.md
# his_peak_builder

Parametrised multi-pixel histogram builder with per-pixel peak search, the next generation of the fixed-size `hisBuilderFSM`. It accumulates TDC timestamps from the dToF front end into one histogram per pixel. On a frame boundary it scans each histogram, reports the peak bin and count per pixel over a valid/ready stream, and clears the histogram for the next frame. It sits between the TDC data stream and the depth/peak post-processing stage.

## Interface
- `TDC_W`, 10, timestamp width (`Np`).
- `BIN_W`, 6, histogram bin index width; `BINS = 2**BIN_W`, `BIN_W <= TDC_W`.
- `PIXELS`, 3, pixels per builder (`PIXEL_NUM_PER_RAM`); `PIX_W = max(1,$clog2(PIXELS))`.
- `CNT_W`, 8, bin counter width.
- `clk`  in  1  single clock; all logic on rising edge.
- `res`  in  1  reset, asynchronous, active-low.
- `wrEn`  in  1  timestamp valid.
- `data`  in  TDC_W  timestamp.
- `pixel`  in  PIX_W  pixel index of `data`.
- `frameEnd`  in  1  one-cycle pulse that closes the current frame.
- `busy`  out  1  the builder is clearing, draining or scanning; samples are not accepted.
- `peakValid`  out  1  result valid.
- `peakReady`  in  1  downstream accepts result.
- `peakPixel`  out  PIX_W  pixel of the result.
- `peakBin`  out  BIN_W  peak bin index.
- `peakCount`  out  CNT_W+2  peak metric, zero-extended.
- `dropCount`  out  16  samples dropped in the current frame; saturates at 0xFFFF.

## Operation
- States: CLEAR, ACCUM, DRAIN, SCAN, OUT.
- **CLEAR**
  - Entered on reset.
  - Writes 0 to all PIXELS*BINS counters, one per cycle, with `busy`=1.
  - Then goes to ACCUM.
- **ACCUM**
  - A sample is accepted when `wrEn`=1 and `pixel` < PIXELS.
  - Bin = `data[TDC_W-1 -: BIN_W]`.
  - The bin counter is updated by a 2-stage read-modify-write and saturates at 2^CNT_W-1.
  - Back-to-back hits to the same pixel/bin are forwarded, so no increment is lost.
- **Dropped samples**
  - A sample is dropped when `wrEn`=1 and either `pixel` >= PIXELS or `busy`=1.
  - Each dropped sample increments `dropCount`.
- **frameEnd**
  - Accepted only in ACCUM.
  - If `wrEn` is high in the same cycle, that sample is counted first.
  - Clears `dropCount` and moves to DRAIN.
  - `frameEnd` while `busy` is ignored.
- **DRAIN**: lasts 2 cycles so the RMW pipeline empties, then goes to SCAN with pixel 0.
- **SCAN**
  - Reads bins 0..BINS-1 of the current pixel, one per cycle, writing 0 behind each read.
  - Tracks the running maximum; a strictly greater value replaces it, so the lowest bin wins ties.
  - An all-zero histogram gives bin 0, count 0.
- **OUT**
  - Holds `peakValid`=1 with stable payload until `peakReady`=1.
  - On handshake, moves to the next pixel (SCAN), or to ACCUM after the last pixel.
- **Reset mid-operation**: any state aborts; the builder re-enters CLEAR and the partial frame is lost.

## Timing
- Reset values:
  - `busy`=1 (CLEAR).
  - `peakValid`=0; `peakPixel`, `peakBin`, `peakCount` = 0.
  - `dropCount`=0.
- `busy` state by phase:
  - Deasserts the cycle ACCUM is entered; CLEAR lasts PIXELS*BINS cycles after `res` rises.
  - Rises the cycle after `frameEnd` is accepted.
  - Falls the cycle after the final handshake.
- Ingest:
  - A sample accepted at cycle t is committed to memory at t+2.
  - Throughput is one sample per cycle.
- Scan:
  - `peakValid` rises BINS+2 cycles after SCAN entry for a pixel (1-cycle memory read latency plus compare register).
  - Without back-pressure, total frame turnaround is 2 + PIXELS*(BINS+3) cycles.
- Width rules:
  - Counters saturate and never wrap.
  - The window sum uses CNT_W+2 bits and cannot overflow.

## Configuration
- `HIS_PEAK3_EN` defined:
  - Peak metric is the 3-bin window sum `cnt[b-1]+cnt[b]+cnt[b+1]`; out-of-range neighbours count as 0.
  - `peakBin` is the window centre b.
  - SCAN takes one extra cycle per pixel: `peakValid` at BINS+3, turnaround 2 + PIXELS*(BINS+4).
- Undefined: metric is `cnt[b]` alone; `peakCount` = zero-extended count.

## Test plan
- **Reset and clear**
  - Stimulus: after `res` deasserts, `frameEnd` with no data.
  - Required: `busy` holds high for 192 cycles (3 px × 64 bins); then 3 results are returned, each with bin 0 and count 0.
- **Single-pixel peak**
  - Stimulus: timestamps 108, 108, 108, 511, 1022, 1022 on pixel 0; then `frameEnd`.
  - Required: pixel 0 → bin 6, count 3; pixels 1 and 2 → bin 0, count 0.
- **Hazard and saturation**
  - Stimulus: 300 consecutive-cycle hits of `data`=1023 on pixel 2.
  - Required: pixel 2 → bin 63, count 255 (no lost or wrapped increments).
- **Tie and back-pressure**
  - Stimulus: pixel 1 gets 2 hits in bin 10 and 2 in bin 40; `peakReady` held low 20 cycles.
  - Required: result is bin 10; payload is stable while stalled.
- **Drops**
  - Stimulus: `pixel`=3 with `wrEn`=1, plus 5 samples sent while `busy`.
  - Required: `dropCount`=6; histograms unaffected; `dropCount` is 0 after the next `frameEnd`.
- **HIS_PEAK3_EN**
  - Stimulus: hits bin4×3, bin5×0, bin6×3, bin20×5.
  - Required: bin 5, count 6 (undefined build: bin 20, count 5).
